multdiv: RTL

MULTDIV -- requirements
Module: multdiv

---
 rtl/multdiv.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/multdiv.sv
// -----------------------------------------------------------------------------
// multdiv -- iterative signed 32-bit multiplier / divider
//
// Multiply uses radix-2 Booth recoding. Divide uses restoring division on
// magnitudes. Both take one iteration per clock. A single 32-bit adder
// instance carries every add and subtract.
//
// Timing: a start strobe sampled at edge t0 loads the operands and enters
// MULT or DIV. Iterations run on edges t0+1 .. t0+32. Edge t0+33 forms the
// final result and enters DONE. data_resultRDY is high for the cycle that
// follows edge t0+33.
//
// Handshake: ctrl_MULT / ctrl_DIV are level strobes sampled on every rising
// edge in any state. A sampled start aborts the operation in progress.
// ctrl_MULT wins when both strobes are high. data_resultRDY is a one-cycle
// valid pulse with no ready back-pressure. data_result and data_exception
// keep their value until a later operation completes.
//
// Ports:
//   clock          in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   data_operandA  in   signed multiplicand / dividend
//   data_operandB  in   signed multiplier / divisor
//   ctrl_MULT      in   start-multiply strobe
//   ctrl_DIV       in   start-divide strobe
//   data_result    out  signed result (low product bits / quotient)
//   data_exception out  product overflow, divide by zero, or MIN / -1
//   data_resultRDY out  one-cycle result-valid pulse (state DONE)
//   busy           out  high in MULT and DIV
//   o_dbg_state    out  current FSM state, for debug and checkers
// -----------------------------------------------------------------------------

// Shared 32-bit ripple adder. Subtraction is done by the caller, which feeds
// the inverted operand with i_cin = 1.
module multdiv_adder32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};
endmodule

module multdiv #(
  parameter int WIDTH = 32  // only 32 is supported
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [5:0]         r_count;
  logic [WIDTH-1:0]   r_hi;      // MULT: product high half, DIV: remainder
  logic [WIDTH-1:0]   r_lo;      // MULT: product low half,  DIV: quotient
  logic               r_qm1;     // Booth q-1 bit
  logic [WIDTH-1:0]   r_opa;     // multiplicand
  logic [WIDTH-1:0]   r_opb;     // signed divisor
  logic               r_neg;     // quotient must be negated
  logic               r_div0;    // divisor was zero
  logic               r_ovf;     // MIN / -1 case
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;

  logic               w_start;
  logic               w_iter;
  logic               w_finish;
  logic [WIDTH-1:0]   w_add_a;
  logic [WIDTH-1:0]   w_add_b;
  logic               w_add_cin;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [1:0]         w_booth;
  logic [WIDTH-1:0]   w_booth_hi;
  logic [WIDTH-1:0]   w_rem_sh;

  assign w_start  = ctrl_MULT | ctrl_DIV;
  // Counter values 0..31 mean iterations are still pending. Value 32 is the
  // result-forming cycle.
  assign w_iter   = ~r_count[5];
  assign w_finish = (r_state == S_MULT || r_state == S_DIV) && !w_iter;
  assign w_booth  = {r_lo[0], r_qm1};
  assign w_rem_sh = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};

  multdiv_adder32 u_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Adder operand selection. On a start cycle the adder forms -A. That value
  // becomes the dividend magnitude when A is negative.
  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_cin = 1'b0;
    if (w_start) begin
      w_add_b   = ~data_operandA;
      w_add_cin = 1'b1;
    end else if (r_state == S_MULT && w_iter) begin
      w_add_a = r_hi;
      if (w_booth == 2'b10) begin
        w_add_b   = ~r_opa;
        w_add_cin = 1'b1;
      end else begin
        w_add_b = r_opa;
      end
    end else if (r_state == S_DIV && w_iter) begin
      // Trial subtract of |B|. For a negative B, rem - |B| equals rem + B.
      // In both forms the carry out is set exactly when rem >= |B|.
      w_add_a = w_rem_sh;
      if (r_opb[WIDTH-1]) begin
        w_add_b = r_opb;
      end else begin
        w_add_b   = ~r_opb;
        w_add_cin = 1'b1;
      end
    end else if (r_state == S_DIV) begin
      // Result-forming cycle: negate the quotient.
      w_add_b   = ~r_lo;
      w_add_cin = 1'b1;
    end
  end

  assign w_booth_hi = (w_booth[1] ^ w_booth[0]) ? w_sum : r_hi;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next state
  always_comb begin
    w_next_state = r_state;
    if (ctrl_MULT) begin
      w_next_state = S_MULT;
    end else if (ctrl_DIV) begin
      w_next_state = S_DIV;
    end else begin
      case (r_state)
        S_IDLE: w_next_state = S_IDLE;
        S_MULT: if (!w_iter) w_next_state = S_DONE;
        S_DIV:  if (!w_iter) w_next_state = S_DONE;
        S_DONE: w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_qm1    <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_neg    <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_start) begin
      r_count <= '0;
      r_hi    <= '0;
      r_qm1   <= 1'b0;
      r_opa   <= data_operandA;
      r_opb   <= data_operandB;
      r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_div0  <= (data_operandB == '0);
      r_ovf   <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (data_operandB == {WIDTH{1'b1}});
      if (ctrl_MULT)                   r_lo <= data_operandB;
      else if (data_operandA[WIDTH-1]) r_lo <= w_sum;
      else                             r_lo <= data_operandA;
    end else if (r_state == S_MULT && w_iter) begin
      // Arithmetic right shift of {hi, lo, q-1} after the Booth add.
      {r_hi, r_lo, r_qm1} <= {w_booth_hi[WIDTH-1], w_booth_hi, r_lo};
      r_count <= r_count + 6'd1;
    end else if (r_state == S_DIV && w_iter) begin
      r_hi    <= w_cout ? w_sum : w_rem_sh;
      r_lo    <= {r_lo[WIDTH-2:0], w_cout};
      r_count <= r_count + 6'd1;
    end else if (w_finish) begin
      if (r_state == S_MULT) begin
        r_result <= r_lo;
        r_exc    <= (r_hi != {WIDTH{r_lo[WIDTH-1]}});
      end else begin
        if (r_div0)     r_result <= '0;
        else if (r_neg) r_result <= w_sum;
        else            r_result <= r_lo;
        r_exc <= r_div0 | r_ovf;
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == S_DONE);
  assign busy           = (r_state == S_MULT) || (r_state == S_DIV);
  assign o_dbg_state    = r_state;

endmodule
